// File: rtl/ins_encode_if.sv
// Field-bundle in / instruction-word out stream between a producer and ins_encode.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready; valid must not wait on ready.
interface ins_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_ins, out_err
  );

  modport slave (
    input  in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_ins, out_err
  );
endinterface

// File: rtl/ins_encode.sv
// Two-stage RV32I encoder: S1 registers the decoded fields, S2 registers the encoded word
// (or a reject flag); saturating counts of delivered good and rejected words.
module ins_encode #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ins_encode_if.slave        bus,
  output logic [COUNT_W-1:0] enc_count,
  output logic [COUNT_W-1:0] err_count
);

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  logic               r_s1_valid;
  logic [4:0]         r_s1_op;
  logic [2:0]         r_s1_f3;
  logic               r_s1_alt;
  logic [4:0]         r_s1_rd;
  logic [4:0]         r_s1_rs1;
  logic [4:0]         r_s1_rs2;
  logic [31:0]        r_s1_imm;
  logic               r_s2_valid;
  logic [31:0]        r_s2_ins;
  logic               r_s2_err;
  logic [COUNT_W-1:0] r_enc_count;
  logic [COUNT_W-1:0] r_err_count;

  logic        w_in_ready;
  logic        w_s2_load;
  logic        w_out_fire;
  logic [6:0]  w_opc;
  logic [6:0]  w_f7;
  logic        w_i_ok;
  logic        w_b_ok;
  logic        w_j_ok;
  logic        w_u_ok;
  logic        w_shift;
  logic [31:0] w_enc;
  logic        w_err;

  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || !r_s2_valid || bus.out_ready;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_ins   = r_s2_ins;
  assign bus.out_err   = r_s2_err;
  assign enc_count     = r_enc_count;
  assign err_count     = r_err_count;

  // Immediate range checks: the bits above each format's sign bit must all replicate it.
  assign w_opc   = {r_s1_op, 2'b11};
  assign w_f7    = r_s1_alt ? 7'b0100000 : 7'b0000000;
  assign w_i_ok  = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
  assign w_b_ok  = ((&r_s1_imm[31:12]) || !(|r_s1_imm[31:12])) && !r_s1_imm[0];
  assign w_j_ok  = ((&r_s1_imm[31:20]) || !(|r_s1_imm[31:20])) && !r_s1_imm[0];
  assign w_u_ok  = (r_s1_imm[11:0] == 12'd0);
  assign w_shift = (r_s1_f3 == 3'b001) || (r_s1_f3 == 3'b101);

  always_comb begin
    w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
    w_err = 1'b0;
    case (r_s1_op)
      OP_LUI, OP_AUIPC: begin
        w_enc = {r_s1_imm[31:12], r_s1_rd, w_opc};
        w_err = !w_u_ok || r_s1_alt;
      end
      OP_JAL: begin
        w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, w_opc};
        w_err = !w_j_ok || r_s1_alt;
      end
      OP_JALR, OP_MISC_MEM: w_err = !w_i_ok || (r_s1_f3 != 3'b000) || r_s1_alt;
      OP_LOAD: w_err = !w_i_ok || r_s1_alt || (r_s1_f3 == 3'b011) || (r_s1_f3[2:1] == 2'b11);
      OP_OP_IMM: begin
        if (w_shift) begin
          // Shift amount is only 5 bits; funct7 comes from alt, never from the immediate.
          w_enc = {w_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
          w_err = (|r_s1_imm[31:5]) || (r_s1_alt && (r_s1_f3 != 3'b101));
        end else begin
          w_err = !w_i_ok || r_s1_alt;
        end
      end
      OP_SYSTEM: w_err = (r_s1_imm[31:1] != 31'd0) || (r_s1_rd != 5'd0) || (r_s1_rs1 != 5'd0)
                         || (r_s1_f3 != 3'b000) || r_s1_alt;
      OP_STORE: begin
        w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], w_opc};
        w_err = !w_i_ok || (r_s1_f3 > 3'b010) || r_s1_alt;
      end
      OP_BRANCH: begin
        w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                 r_s1_imm[4:1], r_s1_imm[11], w_opc};
        w_err = !w_b_ok || (r_s1_f3[2:1] == 2'b01) || r_s1_alt;
      end
      OP_OP: begin
        w_enc = {w_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
        w_err = r_s1_alt && (r_s1_f3 != 3'b000) && (r_s1_f3 != 3'b101);
      end
      default: w_err = 1'b1;
    endcase
    if (w_err) begin
      w_enc = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_f3     <= '0;
      r_s1_alt    <= 1'b0;
      r_s1_rd     <= '0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_imm    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_ins    <= '0;
      r_s2_err    <= 1'b0;
      r_enc_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_op  <= bus.in_op;
          r_s1_f3  <= bus.in_funct3;
          r_s1_alt <= bus.in_alt;
          r_s1_rd  <= bus.in_rd;
          r_s1_rs1 <= bus.in_rs1;
          r_s1_rs2 <= bus.in_rs2;
          r_s1_imm <= bus.in_imm;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        r_s2_ins   <= r_s1_valid ? w_enc : 32'h0000_0000;
        r_s2_err   <= r_s1_valid && w_err;
      end
      if (w_out_fire) begin
        if (!r_s2_err && !(&r_enc_count)) begin
          r_enc_count <= r_enc_count + 1'b1;
        end
        if (r_s2_err && !(&r_err_count)) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ins_encode.sv
// Directed bench for ins_encode: hand-computed encodings, reject cases, pipeline timing,
// backpressure, mid-flight reset, counter saturation and field round-trip of random legal bundles.
module tb_ins_encode;
  localparam int COUNT_W = 4;
  localparam int SAT = (1 << COUNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ins_encode_if bus ();
  logic [COUNT_W-1:0] enc_count;
  logic [COUNT_W-1:0] err_count;

  ins_encode #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {check_ins, err, ins}
  logic [33:0] exp_q[$];
  int m_enc = 0;
  int m_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_enc = 0;
      m_err = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("out_err", bus.out_err, e[32]);
        if (e[33]) chk("out_ins", bus.out_ins, e[31:0]);
        if (bus.out_err) begin
          if (m_err < SAT) m_err++;
        end else begin
          if (m_enc < SAT) m_enc++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic exp_err, input logic [31:0] exp_ins,
                      input logic chk_ins = 1'b1);
    logic acc;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_funct3 = f3;
    bus.in_alt    = alt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        exp_q.push_back({chk_ins, exp_err, exp_ins});
      end
      @(posedge clk);
      #1;
    end
    chk("accept", acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [11:0] r12;
    logic [19:0] r20;
    logic [2:0]  t3;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] ins;

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_funct3 = '0;
    bus.in_alt    = 1'b0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_ins", bus.out_ins, 32'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_enc_count", enc_count, 0);
    chk("rst_err_count", err_count, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: accepted at edge N, visible after edge N+1
    send(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093);
    chk("lat_s1_only", bus.out_valid, 1'b0);
    idle(1);
    chk("lat_out_valid", bus.out_valid, 1'b1);
    chk("lat_addi", bus.out_ins, 32'h00500093);

    send(5'b11011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0, 32'h001000EF); // jal
    send(5'b11000, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 32'hFE000EE3); // beq
    send(5'b11000, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h00000003, 1'b1, 32'h0);
    idle(2);
    chk("first_err_count", err_count, 1);
    chk("enc_count_3", enc_count, 3);

    send(5'b01100, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h402081B3);         // sub
    send(5'b01100, 3'd1, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h0);                 // sll+alt
    send(5'b01101, 3'd3, 1'b0, 5'd5, 5'd7, 5'd9, 32'h12345000, 1'b0, 32'h123452B7);  // lui
    send(5'b01101, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b1, 32'h0);
    send(5'b01000, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423);          // sw
    send(5'b00100, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0, 32'h40335293);          // srai
    send(5'b00100, 3'd1, 1'b0, 5'd5, 5'd6, 5'd0, 32'd32, 1'b1, 32'h0);                // slli 32
    send(5'b11100, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h00000073);          // ecall
    send(5'b11100, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100073);          // ebreak
    send(5'b11100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0);                 // ecall rd!=0
    send(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b0, 32'h80000093);   // addi -2048
    send(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h0);          // addi 2048
    send(5'b00000, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1, 32'h0);                 // load f3 011
    send(5'b00001, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b1, 32'h0);                 // bad opcode
    send(5'b11001, 3'd1, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 32'h0);                 // jalr f3 001
    send(5'b11001, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0, 32'h00008067);          // jalr
    send(5'b00011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h000000FF, 1'b0, 32'h0FF0000F);   // fence
    send(5'b00011, 3'd1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0);                 // fence.i
    send(5'b00100, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 32'h0);                 // addi+alt
    idle(3);
    chk("enc_count_12", enc_count, 12);
    chk("err_count_11", err_count, 11);

    // backpressure: two buffered, third waits, then one per cycle in order
    bus.out_ready = 1'b0;
    send(5'b00100, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100113);
    send(5'b00100, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd2, 1'b0, 32'h00200193);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    chk("bp_head", bus.out_ins, 32'h00100113);
    bus.in_valid  = 1'b1;
    bus.in_rd     = 5'd4;
    bus.in_imm    = 32'd3;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("bp_hold_ready", bus.in_ready, 1'b0);
      chk("bp_hold_ins", bus.out_ins, 32'h00100113);
    end
    bus.out_ready = 1'b1;
    send(5'b00100, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd3, 1'b0, 32'h00300213);
    chk("bp_2nd_valid", bus.out_valid, 1'b1);
    chk("bp_2nd", bus.out_ins, 32'h00200193);
    idle(1);
    chk("bp_3rd", bus.out_ins, 32'h00300213);
    idle(1);
    chk("bp_drained", bus.out_valid, 1'b0);
    chk("enc_sat_bp", enc_count, SAT);

    // asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(5'b00100, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd4, 1'b0, 32'h00400293);
    send(5'b00100, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500313);
    chk("mr_full", bus.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mr_out_valid", bus.out_valid, 1'b0);
    chk("mr_out_ins", bus.out_ins, 32'h0);
    chk("mr_enc_count", enc_count, 0);
    chk("mr_err_count", err_count, 0);
    chk("mr_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(5'b00100, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd6, 1'b0, 32'h00600393);
    idle(1);
    chk("mr_first_valid", bus.out_valid, 1'b1);
    chk("mr_first_ins", bus.out_ins, 32'h00600393);

    // counter saturation (back-to-back, no bubbles)
    for (int i = 0; i < 20; i++) begin
      send(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0, 32'h00000093 | (32'(i) << 20));
    end
    idle(3);
    chk("enc_sat", enc_count, SAT);
    chk("err_zero", err_count, 0);
    for (int i = 0; i < 18; i++) begin
      send(5'b01101, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1000 | 32'(i + 1), 1'b1, 32'h0);
    end
    idle(3);
    chk("err_sat", err_count, SAT);
    chk("enc_sat_hold", enc_count, SAT);

    // round-trip of random legal bundles: re-extract fields from the emitted word
    for (int i = 0; i < 6; i++) begin
      r12 = 12'($urandom_range(0, 4095));
      t3  = 3'($urandom_range(0, 5));
      f3  = (t3 == 3'd0) ? 3'd0 : (t3 < 3'd4) ? t3 + 3'd1 : t3 + 3'd2;
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      imm = {{20{r12[11]}}, r12};
      send(5'b00100, f3, 1'b0, rd, rs1, 5'd0, imm, 1'b0, 32'h0, 1'b0);
      idle(1);
      ins = bus.out_ins;
      chk("rt_i", {ins[11:7], ins[19:15], ins[14:12], {{20{ins[31]}}, ins[31:20]}},
          {rd, rs1, f3, imm});

      r12 = 12'($urandom_range(0, 4095));
      f3  = 3'($urandom_range(0, 2));
      rs2 = 5'($urandom_range(0, 31));
      imm = {{20{r12[11]}}, r12};
      send(5'b01000, f3, 1'b0, 5'd0, rs1, rs2, imm, 1'b0, 32'h0, 1'b0);
      idle(1);
      ins = bus.out_ins;
      chk("rt_s", {ins[24:20], ins[19:15], ins[14:12], {{20{ins[31]}}, ins[31:25], ins[11:7]}},
          {rs2, rs1, f3, imm});

      r12 = 12'($urandom_range(0, 4095));
      t3  = 3'($urandom_range(0, 5));
      f3  = (t3 < 3'd2) ? t3 : t3 + 3'd2;
      imm = {{19{r12[11]}}, r12, 1'b0};
      send(5'b11000, f3, 1'b0, 5'd0, rs1, rs2, imm, 1'b0, 32'h0, 1'b0);
      idle(1);
      ins = bus.out_ins;
      chk("rt_b", {ins[24:20], ins[19:15], ins[14:12],
                   {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}},
          {rs2, rs1, f3, imm});

      r20 = 20'($urandom_range(0, 1048575));
      imm = {{11{r20[19]}}, r20, 1'b0};
      send(5'b11011, 3'd0, 1'b0, rd, 5'd0, 5'd0, imm, 1'b0, 32'h0, 1'b0);
      idle(1);
      ins = bus.out_ins;
      chk("rt_j", {ins[11:7], {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}},
          {rd, imm});
    end
    idle(3);
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    chk("final_enc_model", enc_count, m_enc);
    chk("final_err_model", err_count, m_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
